psram_cmd_seq: RTL

//  Burst sequencer directly upstream of the PSRAM DDR PHY, in the ram_clk domain.
//  - Accepts one read/write burst command per handshake.
//  - Sequences CE#, clock gate, command/address, latency, data and recovery phases.
//  - Drives the PHY's hi/lo DDR data and mask lanes and output enables.
//  - Returns read beats captured from the PHY's input registers.

---
 rtl/psram_cmd_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/psram_cmd_seq.sv
// PSRAM burst sequencer: CE#/clock-gate/cmd/addr/latency/data/recovery toward the DDR PHY.
// Optional `PSRAM_WR_MASK_EN adds a per-beat wr_mask input driving the DM lanes.
module psram_cmd_seq #(
    parameter int BIT_WIDTH = 16,
    parameter int LAT_RD    = 6,
    parameter int LAT_WR    = 6,
    parameter int RD_PIPE   = 2,
    parameter int T_CPH     = 2
) (
    input  logic                   ram_clk,
    input  logic                   ram_rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_we,
    input  logic [31:0]            cmd_addr,
    input  logic [7:0]             cmd_len,
    input  logic [2*BIT_WIDTH-1:0] wr_data,
`ifdef PSRAM_WR_MASK_EN
    input  logic [3:0]             wr_mask,
`endif
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [2*BIT_WIDTH-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   wr_underrun,
    output logic                   busy,
    output logic                   psram_ce,
    output logic                   psram_clk,
    output logic                   dq_en,
    output logic [BIT_WIDTH-1:0]   dq_out_hi,
    output logic [BIT_WIDTH-1:0]   dq_out_lo,
    output logic                   dm_en,
    output logic [1:0]             dm_out_hi,
    output logic [1:0]             dm_out_lo,
    input  logic [BIT_WIDTH-1:0]   dq_in_hi,
    input  logic [BIT_WIDTH-1:0]   dq_in_lo
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, LAT, DATA, DRAIN, RCV} state_t;

    localparam logic [7:0] CPH_LAST = 8'(T_CPH - 1);

    state_t             state, state_nx;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [7:0]         len_q;
    logic [7:0]         cnt;
    logic [7:0]         lat_last;
    logic [7:0]         cmd_byte;
    logic               strobe;
    logic [RD_PIPE-1:0] pipe;
    logic [RD_PIPE:0]   pipe_nx;

    assign lat_last = we_q ? 8'(LAT_WR - 1) : 8'(LAT_RD - 1);
    assign cmd_byte = we_q ? 8'h20 : 8'hA0;
    assign strobe   = (state == DATA) && !we_q;
    assign pipe_nx  = {pipe, strobe};
    assign rd_valid = pipe[RD_PIPE-1];

    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pipe    <= '0;
            rd_data <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state <= state_nx;
            // one counter serves latency, beats and recovery; restarts on every phase change
            cnt   <= (state_nx != state) ? 8'd0 : cnt + 8'd1;
            pipe  <= pipe_nx[RD_PIPE-1:0];
            if (pipe_nx[RD_PIPE-1])
                rd_data <= {dq_in_hi, dq_in_lo};
            if (cmd_valid && cmd_ready) begin
                we_q   <= cmd_we;
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        cmd_ready   = 1'b0;
        busy        = 1'b0;
        wr_ready    = 1'b0;
        wr_underrun = 1'b0;
        psram_ce    = 1'b1;
        psram_clk   = 1'b0;
        dq_en       = 1'b0;
        dm_en       = 1'b0;
        dq_out_hi   = '0;
        dq_out_lo   = '0;
        dm_out_hi   = 2'b00;
        dm_out_lo   = 2'b00;
        if (!ram_rst) begin
            busy = (state != IDLE);
            unique case (state)
                IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) state_nx = CMD;
                end
                CMD: begin
                    psram_ce  = 1'b0;
                    psram_clk = 1'b1;
                    dq_en     = 1'b1;
                    dq_out_hi = {(BIT_WIDTH/8){cmd_byte}};
                    dq_out_lo = {(BIT_WIDTH/8){cmd_byte}};
                    state_nx  = ADDR;
                end
                ADDR: begin
                    psram_ce  = 1'b0;
                    psram_clk = 1'b1;
                    dq_en     = 1'b1;
                    dq_out_hi = BIT_WIDTH'(addr_q[31:16]);
                    dq_out_lo = BIT_WIDTH'(addr_q[15:0]);
                    state_nx  = LAT;
                end
                LAT: begin
                    psram_ce  = 1'b0;
                    psram_clk = 1'b1;
                    if (cnt == lat_last) state_nx = DATA;
                end
                DATA: begin
                    psram_ce  = 1'b0;
                    psram_clk = 1'b1;
                    if (we_q) begin
                        dq_en    = 1'b1;
                        dm_en    = 1'b1;
                        wr_ready = 1'b1;
                        // a missing beat is sent fully masked so the burst never stalls
                        if (wr_valid) begin
                            {dq_out_hi, dq_out_lo} = wr_data;
`ifdef PSRAM_WR_MASK_EN
                            {dm_out_hi, dm_out_lo} = wr_mask;
`endif
                        end else begin
                            {dm_out_hi, dm_out_lo} = 4'hF;
                            wr_underrun            = 1'b1;
                        end
                    end
                    if (cnt == len_q) state_nx = we_q ? RCV : DRAIN;
                end
                DRAIN: begin
                    if (pipe == '0) state_nx = RCV;
                end
                RCV: begin
                    if (cnt == CPH_LAST) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule
